// File: rtl/lemming_tracker.sv
// Tracks a lemming's position, fall length, dig depth and fate, driven by the one-hot
// status vector of the walker FSM directly upstream.
module lemming_tracker #(
  parameter int unsigned POS_INIT    = 128,
  parameter int unsigned SPLAT_LIMIT = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       walk_left,
  input  logic       walk_right,
  input  logic       aaah,
  input  logic       digging,
  input  logic       clear,
  output logic [7:0] pos,
  output logic [4:0] fall_cnt,
  output logic [3:0] depth,
  output logic       dead,
  output logic       splat_pulse,
  output logic       turn_pulse,
  output logic       state_err
);

  localparam logic [7:0] PosInit = 8'(POS_INIT);

  typedef enum logic [1:0] {StGround, StFalling, StDead} state_e;

  state_e     state_q;
  logic       last_left_q;
  logic [2:0] num_high;
  logic       is_err, is_wl, is_wr, is_fall, is_dig, fatal_landing;

  always_comb begin
    num_high = 3'(walk_left) + 3'(walk_right) + 3'(aaah) + 3'(digging);
    is_err   = num_high > 3'd1;
    is_wl    = walk_left  && !is_err;
    is_wr    = walk_right && !is_err;
    is_fall  = aaah       && !is_err;
    is_dig   = digging    && !is_err;
    // Compared against the count before this cycle's update.
    fatal_landing = int'(fall_cnt) > int'(SPLAT_LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StGround;
      pos         <= PosInit;
      fall_cnt    <= 5'd0;
      depth       <= 4'd0;
      last_left_q <= 1'b1;
      dead        <= 1'b0;
      splat_pulse <= 1'b0;
      turn_pulse  <= 1'b0;
      state_err   <= 1'b0;
    end else begin
      splat_pulse <= 1'b0;
      turn_pulse  <= 1'b0;
      if (clear) begin
        state_q     <= StGround;
        pos         <= PosInit;
        fall_cnt    <= 5'd0;
        depth       <= 4'd0;
        last_left_q <= 1'b1;
        dead        <= 1'b0;
        state_err   <= 1'b0;
      end else if (is_err) begin
        state_err <= 1'b1;
      end else if (state_q != StDead) begin
        if (is_fall) begin
          state_q <= StFalling;
          if (fall_cnt != 5'd31) fall_cnt <= fall_cnt + 5'd1;
        end else if (state_q == StFalling && fatal_landing) begin
          // The landing cycle's move is lost: the lemming is already dead.
          state_q     <= StDead;
          dead        <= 1'b1;
          splat_pulse <= 1'b1;
          fall_cnt    <= 5'd0;
        end else begin
          if (state_q == StFalling) begin
            state_q  <= StGround;
            fall_cnt <= 5'd0;
          end
          if (is_wl) begin
            if (pos != 8'd0) pos <= pos - 8'd1;
            depth       <= 4'd0;
            turn_pulse  <= !last_left_q;
            last_left_q <= 1'b1;
          end else if (is_wr) begin
            if (pos != 8'd255) pos <= pos + 8'd1;
            depth       <= 4'd0;
            turn_pulse  <= last_left_q;
            last_left_q <= 1'b0;
          end else if (is_dig) begin
            if (depth != 4'd15) depth <= depth + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lemming_tracker.sv
// Scoreboard bench for lemming_tracker: the driver pushes expected outputs per cycle,
// a monitor pops and compares them after each rising edge.
module tb_lemming_tracker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       walk_left = 0, walk_right = 0, aaah = 0, digging = 0, clear = 0;
  logic [7:0] pos;
  logic [4:0] fall_cnt;
  logic [3:0] depth;
  logic       dead, splat_pulse, turn_pulse, state_err;

  lemming_tracker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .walk_left  (walk_left),
    .walk_right (walk_right),
    .aaah       (aaah),
    .digging    (digging),
    .clear      (clear),
    .pos        (pos),
    .fall_cnt   (fall_cnt),
    .depth      (depth),
    .dead       (dead),
    .splat_pulse(splat_pulse),
    .turn_pulse (turn_pulse),
    .state_err  (state_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pos; int fall; int depth; int dead; int splat; int turn; int err;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  int  m_pos, m_fall, m_depth;
  bit  m_dead, m_err, m_left, m_falling, m_splat, m_turn;

  localparam logic [4:0] WL = 5'b00001, WR = 5'b00010, FA = 5'b00100, DG = 5'b01000,
                         CL = 5'b10000, ID = 5'b00000;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 128; m_fall = 0; m_depth = 0; m_dead = 0; m_err = 0;
    m_left = 1; m_falling = 0; m_splat = 0; m_turn = 0;
  endtask

  task automatic model_step(input logic [4:0] v);
    int n;
    m_splat = 0; m_turn = 0;
    n = v[0] + v[1] + v[2] + v[3];
    if (v[4]) model_reset();
    else if (n > 1) m_err = 1;
    else if (!m_dead) begin
      if (v[2]) begin
        m_falling = 1;
        m_fall = (m_fall < 31) ? m_fall + 1 : 31;
      end else if (m_falling && m_fall > 20) begin
        m_falling = 0; m_fall = 0; m_dead = 1; m_splat = 1;
      end else begin
        m_falling = 0; m_fall = 0;
        if (v[0]) begin
          m_turn = !m_left; m_left = 1; m_depth = 0;
          m_pos = (m_pos > 0) ? m_pos - 1 : 0;
        end else if (v[1]) begin
          m_turn = m_left; m_left = 0; m_depth = 0;
          m_pos = (m_pos < 255) ? m_pos + 1 : 255;
        end else if (v[3]) begin
          m_depth = (m_depth < 15) ? m_depth + 1 : 15;
        end
      end
    end
  endtask

  task automatic step(input logic [4:0] v);
    exp_t e;
    @(negedge clk);
    {clear, digging, aaah, walk_right, walk_left} = v;
    model_step(v);
    e.pos = m_pos; e.fall = m_fall; e.depth = m_depth; e.dead = m_dead;
    e.splat = m_splat; e.turn = m_turn; e.err = m_err;
    q.push_back(e);
  endtask

  task automatic steps(input logic [4:0] v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pos"}, pos, 128);
    check({tag, "_fall"}, fall_cnt, 0);
    check({tag, "_depth"}, depth, 0);
    check({tag, "_dead"}, dead, 0);
    check({tag, "_splat"}, splat_pulse, 0);
    check({tag, "_turn"}, turn_pulse, 0);
    check({tag, "_err"}, state_err, 0);
  endtask

  // Monitor: outputs are valid after every edge; compare whenever an expectation is queued
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("sb_pos", pos, e.pos);
        check("sb_fall_cnt", fall_cnt, e.fall);
        check("sb_depth", depth, e.depth);
        check("sb_dead", dead, e.dead);
        check("sb_splat_pulse", splat_pulse, e.splat);
        check("sb_turn_pulse", turn_pulse, e.turn);
        check("sb_state_err", state_err, e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Walk right three times then left once
    steps(WR, 3);
    step(WL);
    settle();
    check("walk_pos", pos, 130);
    check("walk_turn_after_wl", turn_pulse, 1);

    // Survivable fall of exactly the limit
    step(CL);
    steps(FA, 20);
    settle();
    check("fall20_cnt", fall_cnt, 20);
    step(WL);
    settle();
    check("fall20_landed_cnt", fall_cnt, 0);
    check("fall20_dead", dead, 0);

    // Fatal fall, then frozen while dead, then clear
    steps(FA, 21);
    step(WR);
    settle();
    check("splat_dead", dead, 1);
    check("splat_pulse", splat_pulse, 1);
    steps(WR, 2);
    steps(DG, 1);
    settle();
    check("dead_pulse_gone", splat_pulse, 0);
    step(CL | WR);
    settle();
    check("clear_prio_pos", pos, 128);
    check("clear_dead", dead, 0);

    // Async reset while dead, asserted between edges
    steps(FA, 21);
    step(WL);
    settle();
    check("dead_before_async", dead, 1);
    @(negedge clk);
    {clear, digging, aaah, walk_right, walk_left} = ID;
    #2 rst_n = 1'b0;
    #1 check_reset_values("async");
    #1 rst_n = 1'b1;
    model_reset();

    // Saturation of pos and depth, then turn back right
    steps(WL, 130);
    steps(DG, 20);
    settle();
    check("sat_pos", pos, 0);
    check("sat_depth", depth, 15);
    step(WR);
    settle();
    check("wr_pos", pos, 1);
    check("wr_depth", depth, 0);
    check("wr_turn", turn_pulse, 1);

    // Non-one-hot input mid-fall
    steps(FA, 5);
    step(WL | FA);
    settle();
    check("err_flag", state_err, 1);
    check("err_fall_hold", fall_cnt, 5);
    steps(FA, 2);
    settle();
    check("err_resume", fall_cnt, 7);
    step(WL);
    step(ID);
    settle();
    check("err_sticky", state_err, 1);
    step(CL);
    settle();
    check("err_cleared", state_err, 0);

    @(posedge clk);
    #3;
    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
